light_transceiver: RTL and testbench

Parametrised half-duplex-per-direction optical link transceiver: serialises a `DATA_WIDTH`-bit word onto the `led` line and deserialises frames arriving on `signal`, with configurable oversampling, optional even parity and a metastability-safe receive path. Two instances are cross-connected (led to signal) in the LightIO link. They may run on independent, arbitrarily phased clocks of equal nominal frequency. The block adds to the current single-width, unframed transceiver:

- width and bit-period generics
- majority-vote sampling
- glitch rejection
- parity and framing error reporting

---
 rtl/light_transceiver.sv | 187 ++++++++++++++++++
 tb/tb_light_transceiver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_transceiver.sv
`timescale 1ns/1ps
// light_transceiver: oversampled start/stop optical link transceiver with optional even
// parity, majority-vote receive sampling, glitch rejection and error reporting.
module light_transceiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 4,
    parameter int PARITY_EN   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  led,
    output logic                  tx_busy,
    output logic                  irq_tx,
    input  logic                  signal,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  irq_rx,
    output logic                  rx_error
);
    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam int IX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int H    = OVERSAMPLE / 2;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_S0   = PH_W'(H - 1);
    localparam logic [PH_W-1:0] PH_S1   = PH_W'(H);
    localparam logic [PH_W-1:0] PH_DEC  = PH_W'(H + 1);
    localparam logic [IX_W-1:0] IX_LAST = IX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                r_tx_st;
    logic [PH_W-1:0]       r_tx_ph;
    logic [IX_W-1:0]       r_tx_idx;
    logic [DATA_WIDTH-1:0] r_tx_sh;
    logic                  r_tx_par;
    logic                  w_tx_load;
    logic                  w_tx_bit_end;
    logic [DATA_WIDTH-1:0] w_tx_next;

    assign w_tx_load    = (r_tx_st == S_IDLE) && tx_enable;
    assign w_tx_bit_end = (r_tx_st != S_IDLE) && (r_tx_ph == PH_LAST);
    assign w_tx_next    = r_tx_sh >> 1;

    always_ff @(posedge clock) begin
        if (w_tx_load) begin
            r_tx_sh  <= data_in;
            r_tx_par <= ^data_in;
        end else if (w_tx_bit_end && r_tx_st == S_DATA) begin
            r_tx_sh <= w_tx_next;
        end
    end

    // led changes only on bit boundaries; the stop bit is the idle level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_st  <= S_IDLE;
            r_tx_ph  <= '0;
            r_tx_idx <= '0;
            led      <= 1'b0;
            tx_busy  <= 1'b0;
            irq_tx   <= 1'b0;
        end else begin
            irq_tx <= 1'b0;
            if (r_tx_st == S_IDLE) begin
                if (tx_enable) begin
                    r_tx_st <= S_START;
                    r_tx_ph <= '0;
                    tx_busy <= 1'b1;
                    led     <= 1'b1;
                end
            end else if (r_tx_ph != PH_LAST) begin
                r_tx_ph <= r_tx_ph + PH_W'(1);
            end else begin
                r_tx_ph <= '0;
                case (r_tx_st)
                    S_START: begin
                        r_tx_st  <= S_DATA;
                        r_tx_idx <= '0;
                        led      <= r_tx_sh[0];
                    end
                    S_DATA: begin
                        if (r_tx_idx == IX_LAST) begin
                            r_tx_st <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            led     <= (PARITY_EN != 0) ? r_tx_par : 1'b0;
                        end else begin
                            r_tx_idx <= r_tx_idx + IX_W'(1);
                            led      <= w_tx_next[0];
                        end
                    end
                    S_PARITY: begin
                        r_tx_st <= S_STOP;
                        led     <= 1'b0;
                    end
                    default: begin
                        r_tx_st <= S_IDLE;
                        tx_busy <= 1'b0;
                        irq_tx  <= 1'b1;
                        led     <= 1'b0;
                    end
                endcase
            end
        end
    end

    state_t                 r_rx_st;
    logic [PH_W-1:0]        r_rx_ph;
    logic [IX_W-1:0]        r_rx_idx;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_s0;
    logic                   r_s1;
    logic [DATA_WIDTH-1:0]  r_rx_sh;
    logic                   r_rx_pbit;
    logic                   w_synced;
    logic                   w_maj;
    logic                   w_rx_dec;
    logic                   w_par_ok;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_maj    = (r_s0 & r_s1) | (r_s0 & w_synced) | (r_s1 & w_synced);
    assign w_rx_dec = (r_rx_st != S_IDLE) && (r_rx_ph == PH_DEC);
    assign w_par_ok = (PARITY_EN == 0) || ((^r_rx_sh) == r_rx_pbit);

    always_ff @(posedge clock) begin
        if (r_rx_st != S_IDLE) begin
            if (r_rx_ph == PH_S0) r_s0 <= w_synced;
            if (r_rx_ph == PH_S1) r_s1 <= w_synced;
        end
        if (w_rx_dec && r_rx_st == S_DATA)   r_rx_sh[r_rx_idx] <= w_maj;
        if (w_rx_dec && r_rx_st == S_PARITY) r_rx_pbit <= w_maj;
    end

    // Synchroniser and prev reset high so a line already high at release is not a start edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync   <= '1;
            r_prev   <= 1'b1;
            r_rx_st  <= S_IDLE;
            r_rx_ph  <= '0;
            r_rx_idx <= '0;
            data_out <= '0;
            irq_rx   <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], signal};
            r_prev   <= w_synced;
            irq_rx   <= 1'b0;
            rx_error <= 1'b0;
            if (r_rx_st == S_IDLE) begin
                if (w_synced && !r_prev) begin
                    r_rx_st <= S_START;
                    r_rx_ph <= '0;
                end
            end else begin
                r_rx_ph <= (r_rx_ph == PH_LAST) ? '0 : r_rx_ph + PH_W'(1);
                if (w_rx_dec && r_rx_st == S_START && !w_maj) begin
                    r_rx_st <= S_IDLE;
                end else if (w_rx_dec && r_rx_st == S_STOP) begin
                    r_rx_st <= S_IDLE;
                    if (!w_maj && w_par_ok) begin
                        data_out <= r_rx_sh;
                        irq_rx   <= 1'b1;
                    end else begin
                        rx_error <= 1'b1;
                    end
                end else if (r_rx_ph == PH_LAST) begin
                    case (r_rx_st)
                        S_START: begin
                            r_rx_st  <= S_DATA;
                            r_rx_idx <= '0;
                        end
                        S_DATA: begin
                            if (r_rx_idx == IX_LAST)
                                r_rx_st <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            else
                                r_rx_idx <= r_rx_idx + IX_W'(1);
                        end
                        S_PARITY: r_rx_st <= S_STOP;
                        default:  r_rx_st <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_light_transceiver.sv
`timescale 1ns/1ps
// Bench for light_transceiver: loopback, phased-clock link, back-to-back, error injection,
// glitch rejection, alternate generics and mid-frame reset against a frame-level model.
module tb_light_transceiver;
  localparam int DW = 8, OS = 4, PE = 1, SS = 2;
  localparam int NB = 2 + DW + PE;
  localparam int F = NB * OS;
  localparam int RXL = SS + 1 + (NB - 1) * OS + OS / 2 + 2;
  localparam int GDW = 12, GOS = 6, GPE = 0;
  localparam int GNB = 2 + GDW + GPE;
  localparam int GF = GNB * GOS;
  localparam int GRXL = SS + 1 + (GNB - 1) * GOS + GOS / 2 + 2;

  logic clk = 1'b0, clk_b = 1'b0, rst = 1'b1;
  logic tx_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic led, busy, irq_tx, irq_rx, rx_err, sig;
  logic [DW-1:0] dout;
  logic inj_en = 1'b0, inj = 1'b0;
  logic b_led, b_busy, b_irq_tx, b_irq_rx, b_err;
  logic [DW-1:0] b_dout;
  logic g_tx_en = 1'b0;
  logic [GDW-1:0] g_din = '0;
  logic g_led, g_busy, g_irq_tx, g_irq_rx, g_err;
  logic [GDW-1:0] g_dout;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int q_tx[$], q_rx_c[$], q_rx_w[$], q_err[$], qb_w[$];
  int qg_tx[$], qg_rx_c[$], qg_rx_w[$];
  int qb_err = 0, qg_err = 0;

  assign sig = inj_en ? inj : led;

  light_transceiver dut (
    .clock(clk), .reset(rst), .tx_enable(tx_en), .data_in(din), .led(led), .tx_busy(busy),
    .irq_tx(irq_tx), .signal(sig), .data_out(dout), .irq_rx(irq_rx), .rx_error(rx_err));

  light_transceiver dut_b (
    .clock(clk_b), .reset(rst), .tx_enable(1'b0), .data_in({DW{1'b0}}), .led(b_led),
    .tx_busy(b_busy), .irq_tx(b_irq_tx), .signal(led), .data_out(b_dout), .irq_rx(b_irq_rx),
    .rx_error(b_err));

  light_transceiver #(.DATA_WIDTH(GDW), .OVERSAMPLE(GOS), .PARITY_EN(GPE), .SYNC_STAGES(SS)) dut_g (
    .clock(clk), .reset(rst), .tx_enable(g_tx_en), .data_in(g_din), .led(g_led), .tx_busy(g_busy),
    .irq_tx(g_irq_tx), .signal(g_led), .data_out(g_dout), .irq_rx(g_irq_rx), .rx_error(g_err));

  always #1 clk = ~clk;
  initial begin
    #0.75;
    forever #1 clk_b = ~clk_b;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (irq_tx) q_tx.push_back(cyc);
    if (irq_rx) begin q_rx_c.push_back(cyc); q_rx_w.push_back(int'(dout)); end
    if (rx_err) q_err.push_back(cyc);
    if (g_irq_tx) qg_tx.push_back(cyc);
    if (g_irq_rx) begin qg_rx_c.push_back(cyc); qg_rx_w.push_back(int'(g_dout)); end
    if (g_err) qg_err++;
  end

  always @(negedge clk_b) begin
    if (b_irq_rx) qb_w.push_back(int'(b_dout));
    if (b_err) qb_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line level of bit b of a frame: start 1, data LSB first, optional even parity, stop 0
  function automatic logic frame_bit(input logic [31:0] w, input int dw, input int pe, input int b);
    if (b == 0) return 1'b1;
    if (b <= dw) return w[b-1];
    if (pe != 0 && b == dw + 1) return ^(w & ((32'h1 << dw) - 1));
    return 1'b0;
  endfunction

  task automatic clear_q();
    q_tx.delete(); q_rx_c.delete(); q_rx_w.delete(); q_err.delete(); qb_w.delete();
    qg_tx.delete(); qg_rx_c.delete(); qg_rx_w.delete();
    qb_err = 0; qg_err = 0;
  endtask

  task automatic send_watch(input logic [DW-1:0] w, output int c0);
    @(negedge clk); din = w; tx_en = 1'b1;
    @(negedge clk); c0 = cyc; tx_en = 1'b0;
    for (int n = 0; n < F; n++) begin
      check("led", led, frame_bit(w, DW, PE, n / OS));
      check("tx_busy", busy, 1);
      @(negedge clk);
    end
    check("led_end", led, 0);
    check("busy_end", busy, 0);
    check("irq_tx_pulse", irq_tx, 1);
  endtask

  task automatic check_rx1(input string tag, input int c0, input int w);
    check({tag, "_ntx"}, q_tx.size(), 1);
    check({tag, "_txlat"}, (q_tx.size() > 0) ? q_tx[0] - c0 : -1, F);
    check({tag, "_nrx"}, q_rx_c.size(), 1);
    check({tag, "_rxlat"}, (q_rx_c.size() > 0) ? q_rx_c[0] - c0 : -1, RXL);
    check({tag, "_word"}, (q_rx_w.size() > 0) ? q_rx_w[0] : -1, w);
    check({tag, "_nerr"}, q_err.size(), 0);
    check({tag, "_dout"}, dout, w);
  endtask

  task automatic inject(input logic [7:0] w, input logic par, input logic stp, output int c0);
    logic v;
    c0 = 0;
    for (int b = 0; b < NB; b++) begin
      if (b == 0) v = 1'b1;
      else if (b <= DW) v = w[b-1];
      else if (b == DW + 1) v = par;
      else v = stp;
      @(negedge clk); inj = v;
      if (b == 0) c0 = cyc;
      repeat (OS - 1) @(negedge clk);
    end
  endtask

  task automatic send_g(input logic [GDW-1:0] w);
    int c0;
    clear_q();
    @(negedge clk); g_din = w; g_tx_en = 1'b1;
    @(negedge clk); c0 = cyc; g_tx_en = 1'b0;
    for (int n = 0; n < GF; n++) begin
      check("g_led", g_led, frame_bit(w, GDW, GPE, n / GOS));
      check("g_busy", g_busy, 1);
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("g_ntx", qg_tx.size(), 1);
    check("g_txlat", (qg_tx.size() > 0) ? qg_tx[0] - c0 : -1, GF);
    check("g_nrx", qg_rx_c.size(), 1);
    check("g_rxlat", (qg_rx_c.size() > 0) ? qg_rx_c[0] - c0 : -1, GRXL);
    check("g_word", (qg_rx_w.size() > 0) ? qg_rx_w[0] : -1, w);
    check("g_nerr", qg_err, 0);
  endtask

  initial begin
    int c0;
    logic [DW-1:0] w;
    int exp_w[$];

    #0.5 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_irq_tx", irq_tx, 0);
    check("rst_dout", dout, 0);
    check("rst_irq_rx", irq_rx, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_b_outs", {b_led, b_busy, b_irq_tx}, 0);
    check("rst_g_outs", {g_led, g_busy, g_irq_tx}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    clear_q();
    send_watch(8'h96, c0);
    repeat (10) @(negedge clk);
    check_rx1("single", c0, 8'h96);

    for (int k = 0; k < 4; k++) begin
      w = 8'($urandom_range(0, 255));
      clear_q();
      send_watch(w, c0);
      repeat (10) @(negedge clk);
      check_rx1("rand", c0, w);
    end

    clear_q();
    @(negedge clk); din = 8'h00; tx_en = 1'b1;
    @(negedge clk); c0 = cyc; din = 8'hFF;
    repeat (F + 1) @(negedge clk); din = 8'hA5;
    repeat (F + 1) @(negedge clk); tx_en = 1'b0;
    repeat (F + 20) @(negedge clk);
    exp_w = '{8'h00, 8'hFF, 8'hA5};
    check("b2b_ntx", q_tx.size(), 3);
    check("b2b_nrx", q_rx_w.size(), 3);
    for (int i = 0; i < q_rx_w.size() && i < 3; i++) begin
      check("b2b_word", q_rx_w[i], exp_w[i]);
      check("b2b_rxlat", q_rx_c[i] - c0, RXL + i * (F + 1));
    end
    check("b2b_nerr", q_err.size(), 0);

    clear_q();
    exp_w.delete();
    for (int k = 0; k < 32; k++) begin
      w = 8'($urandom_range(0, 255));
      exp_w.push_back(int'(w));
      @(negedge clk); din = w; tx_en = 1'b1;
      @(negedge clk); tx_en = 1'b0;
      repeat (F) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    check("ph_nrx", qb_w.size(), 32);
    for (int i = 0; i < qb_w.size() && i < 32; i++) check("ph_word", qb_w[i], exp_w[i]);
    check("ph_nerr", qb_err, 0);
    check("ph_b_led", b_led, 0);

    @(negedge clk); inj = 1'b0; inj_en = 1'b1;
    repeat (4) @(negedge clk);
    clear_q();
    inject(8'h5A, 1'b0, 1'b0, c0);
    repeat (12) @(negedge clk);
    check("inj_ok_nrx", q_rx_w.size(), 1);
    check("inj_ok_word", (q_rx_w.size() > 0) ? q_rx_w[0] : -1, 8'h5A);
    check("inj_ok_rxlat", (q_rx_c.size() > 0) ? q_rx_c[0] - c0 : -1, RXL);
    check("inj_ok_nerr", q_err.size(), 0);

    clear_q();
    inject(8'h96, 1'b1, 1'b0, c0);
    repeat (12) @(negedge clk);
    check("par_nerr", q_err.size(), 1);
    check("par_errlat", (q_err.size() > 0) ? q_err[0] - c0 : -1, RXL);
    check("par_nrx", q_rx_w.size(), 0);
    check("par_dout_held", dout, 8'h5A);

    clear_q();
    inject(8'h3C, 1'b0, 1'b1, c0);
    repeat (40) @(negedge clk);
    check("stop_nerr", q_err.size(), 1);
    check("stop_errlat", (q_err.size() > 0) ? q_err[0] - c0 : -1, RXL);
    check("stop_nrx", q_rx_w.size(), 0);
    check("stop_dout_held", dout, 8'h5A);

    @(negedge clk); inj = 1'b0;
    repeat (4) @(negedge clk);
    clear_q();
    @(negedge clk); inj = 1'b1;
    @(negedge clk); inj = 1'b0;
    repeat (F) @(negedge clk);
    check("glitch_nrx", q_rx_w.size(), 0);
    check("glitch_nerr", q_err.size(), 0);
    check("glitch_dout", dout, 8'h5A);
    inj_en = 1'b0;

    send_g(12'hABC);
    send_g(12'($urandom_range(0, 4095)));

    clear_q();
    @(negedge clk); din = 8'h3C; tx_en = 1'b1;
    @(negedge clk); tx_en = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #0.2;
    check("mid_led", led, 0);
    check("mid_busy", busy, 0);
    check("mid_irq_tx", irq_tx, 0);
    check("mid_dout", dout, 0);
    check("mid_irq_rx", irq_rx, 0);
    check("mid_rx_err", rx_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_q();
    repeat (F + 10) @(negedge clk);
    check("post_led", led, 0);
    check("post_ntx", q_tx.size(), 0);
    check("post_nrx", q_rx_w.size(), 0);
    check("post_nerr", q_err.size(), 0);

    clear_q();
    send_watch(8'hC3, c0);
    repeat (10) @(negedge clk);
    check_rx1("recover", c0, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
